pio_in_edge_irq: RTL and testbench

- Parametrised Avalon-MM input PIO. Successor to the single-bit edge-capture input port.
- Accepts WIDTH asynchronous inputs and runs each through a synchroniser and a programmable debounce filter.
- Captures per-bit rising and/or falling edges and raises a maskable level interrupt.
- Sits on the HPS/Nios lightweight bus next to the sensor interrupt lines, e.g. the IMU INT and the wheel-encoder index pins.

---
 rtl/pio_in_edge_irq_if.sv | 24 ++
 rtl/pio_in_edge_irq.sv | 125 ++++++++++++
 tb/tb_pio_in_edge_irq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capture input PIO.
interface pio_in_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_edge_irq.sv
// WIDTH-channel input PIO: synchroniser, programmable debounce, per-bit
// rise/fall edge capture with W1C clear and a maskable level interrupt.
module pio_in_edge_irq #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      DEB_W       = 8,
    parameter logic [WIDTH-1:0] RISE_RST    = '1,
    parameter logic [WIDTH-1:0] FALL_RST    = '0
) (
    input  logic             clk,
    input  logic             reset,
    pio_in_edge_irq_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAP  = 3'd3;
    localparam logic [2:0] ADDR_FALL = 3'd4;
    localparam logic [2:0] ADDR_DEB  = 3'd5;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_filt;
    logic [WIDTH-1:0] r_filt_d;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [DEB_W-1:0] r_deb;
    logic [DEB_W-1:0] r_cnt [WIDTH];

    logic             w_wr;
    logic             w_wr_deb;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_deb_le1;
    logic [DEB_W-1:0] w_deb_last;
    logic             w_unused_wdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_wr_deb       = w_wr && (bus.address == ADDR_DEB);
    assign w_s            = r_sync[SYNC_STAGES-1];
    assign w_deb_le1      = (r_deb <= DEB_W'(1));
    assign w_deb_last     = r_deb - DEB_W'(1);
    assign w_edge         = (r_filt & ~r_filt_d & r_rise_en) | (~r_filt & r_filt_d & r_fall_en);
    assign w_clr          = (w_wr && (bus.address == ADDR_CAP)) ? bus.writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^bus.writedata;

    // Metastability chain on the raw pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // filt follows s only once s has differed for DEBOUNCE consecutive cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (w_s[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_deb_le1 || (r_cnt[i] == w_deb_last)) begin
                    r_filt[i] <= w_s[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DEB_W'(1);
                end
                if (w_wr_deb) r_cnt[i] <= '0;
            end
        end
    end

    // Control registers; a new edge wins over a same-cycle W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt_d  <= '0;
            r_rise_en <= RISE_RST;
            r_fall_en <= FALL_RST;
            r_mask    <= '0;
            r_cap     <= '0;
            r_deb     <= '0;
        end else begin
            r_filt_d <= r_filt;
            r_cap    <= (r_cap & ~w_clr) | w_edge;
            if (w_wr) begin
                case (bus.address)
                    ADDR_RISE: r_rise_en <= bus.writedata[WIDTH-1:0];
                    ADDR_MASK: r_mask    <= bus.writedata[WIDTH-1:0];
                    ADDR_FALL: r_fall_en <= bus.writedata[WIDTH-1:0];
                    ADDR_DEB:  r_deb     <= bus.writedata[DEB_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    // Read data registered every cycle from address, chipselect not required
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                ADDR_DATA: bus.readdata <= 32'(r_filt);
                ADDR_RISE: bus.readdata <= 32'(r_rise_en);
                ADDR_MASK: bus.readdata <= 32'(r_mask);
                ADDR_CAP:  bus.readdata <= 32'(r_cap);
                ADDR_FALL: bus.readdata <= 32'(r_fall_en);
                ADDR_DEB:  bus.readdata <= 32'(r_deb);
                default:   bus.readdata <= '0;
            endcase
        end
    end

    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: register-map vector table plus hand-written
// latency, debounce, W1C-collision and reset sequences.
module tb_pio_in_edge_irq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_port = 8'h00;
    logic       irq;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    pio_in_edge_irq_if bus_if ();

    pio_in_edge_irq #(
        .WIDTH(8), .SYNC_STAGES(2), .DEB_W(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_if),
        .in_port(in_port),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t tbl [20];
    sb_t  sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp, input string name);
        sb_t e;
        bus_if.address = addr;
        sb_q.push_back('{name, exp});
        tick();
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.name, bus_if.readdata, e.exp);
        end
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].wdata);
            bus_read(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_a%0d", i, tbl[i].addr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_one;

        tbl[0]  = '{1'b0, 3'd0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 3'd1, 32'h0,        32'hFF};
        tbl[2]  = '{1'b0, 3'd2, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 3'd3, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 3'd4, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 3'd5, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 3'd6, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 3'd7, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 3'd1, 32'h1A5,      32'hA5};
        tbl[9]  = '{1'b1, 3'd2, 32'hFFFFFF3C, 32'h3C};
        tbl[10] = '{1'b1, 3'd4, 32'h0F,       32'h0F};
        tbl[11] = '{1'b1, 3'd5, 32'h1234,     32'h34};
        tbl[12] = '{1'b1, 3'd6, 32'hFF,       32'h0};
        tbl[13] = '{1'b1, 3'd0, 32'hFF,       32'h0};
        tbl[14] = '{1'b1, 3'd3, 32'hFF,       32'h0};
        tbl[15] = '{1'b1, 3'd7, 32'hFF,       32'h0};
        tbl[16] = '{1'b1, 3'd1, 32'hFF,       32'hFF};
        tbl[17] = '{1'b1, 3'd2, 32'h0,        32'h0};
        tbl[18] = '{1'b1, 3'd4, 32'h0,        32'h0};
        tbl[19] = '{1'b1, 3'd5, 32'h0,        32'h0};

        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;

        // reset defaults and register map
        #23;
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", bus_if.readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_table(0, 19);

        // rising-edge latency: SYNC_STAGES+2 edges
        bus_write(3'd2, 32'h01);
        in_port[0] = 1'b1;
        tick(); tick(); tick();
        check("rise_irq_k2", 32'(irq), 32'h0);
        tick();
        check("rise_irq_k3", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h01, "rise_cap");
        bus_read(3'd0, 32'h01, "rise_data");
        bus_write(3'd3, 32'h00);
        bus_read(3'd3, 32'h01, "w1c_zero_nochange");
        bus_write(3'd3, 32'h01);
        check("w1c_irq_clear", 32'(irq), 32'h0);
        bus_read(3'd3, 32'h00, "w1c_cap_clear");

        // falling and both-edge modes
        bus_write(3'd1, 32'h04);
        bus_write(3'd4, 32'h0C);
        bus_write(3'd2, 32'hFF);
        in_port = 8'h0D;
        repeat (5) tick();
        bus_read(3'd3, 32'h04, "both_rise_cap");
        bus_write(3'd3, 32'h04);
        repeat (3) tick();
        in_port = 8'h01;
        repeat (5) tick();
        bus_read(3'd3, 32'h0C, "fall_cap");
        check("fall_irq", 32'(irq), 32'h1);
        bus_write(3'd3, 32'hFF);
        in_port = 8'h03;
        repeat (4) tick();
        bus_read(3'd0, 32'h03, "bit1_data");
        in_port = 8'h01;
        repeat (5) tick();
        bus_read(3'd3, 32'h00, "bit1_ignored");

        // debounce = 5
        in_port = 8'h00;
        repeat (5) tick();
        bus_write(3'd1, 32'h01);
        bus_write(3'd4, 32'h00);
        bus_write(3'd2, 32'h01);
        bus_write(3'd3, 32'hFF);
        bus_write(3'd5, 32'h05);
        bus_read(3'd3, 32'h00, "deb_pre_cap");
        bus_if.address = 3'd0;
        saw_one = 1'b0;
        in_port[0] = 1'b1;
        repeat (4) begin tick(); saw_one |= bus_if.readdata[0]; end
        in_port[0] = 1'b0;
        repeat (8) begin tick(); saw_one |= bus_if.readdata[0]; end
        check("glitch_data", 32'(saw_one), 32'h0);
        bus_read(3'd3, 32'h00, "glitch_cap");
        bus_if.address = 3'd0;
        in_port[0] = 1'b1;
        repeat (6) tick();
        in_port[0] = 1'b0;
        tick();
        check("deb_data_k6", bus_if.readdata, 32'h0);
        check("deb_irq_k6", 32'(irq), 32'h0);
        tick();
        check("deb_data_k7", bus_if.readdata, 32'h1);
        check("deb_irq_k7", 32'(irq), 32'h1);

        // W1C on the same edge as a new capture: set wins
        bus_write(3'd5, 32'h00);
        repeat (6) tick();
        check("pre_collide_irq", 32'(irq), 32'h1);
        in_port[0] = 1'b1;
        tick(); tick(); tick();
        bus_write(3'd3, 32'h01);
        check("collide_irq", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h01, "collide_cap");

        // mask gating, then reset mid-debounce
        bus_write(3'd2, 32'h00);
        check("mask_off_irq", 32'(irq), 32'h0);
        bus_write(3'd2, 32'h01);
        check("mask_on_irq", 32'(irq), 32'h1);
        bus_write(3'd5, 32'h08);
        in_port[0] = 1'b0;
        repeat (5) tick();
        check("pre_reset_irq", 32'(irq), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_irq", 32'(irq), 32'h0);
        check("async_reset_rd", bus_if.readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_table(0, 7);
        check("post_reset_irq", 32'(irq), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
